// File: rtl/perm_sched_pkg.sv
// Shared definitions for the permutation request scheduler.
//   - FSM state encoding
//   - clog2_min1(): ceiling log2 clamped to at least 1, used to size id and timer fields
//   - RSP_ERR_TIMEOUT: value driven on rsp_err when the unit fails to finish in time
package perm_sched_pkg;

  localparam logic [2:0] ST_IDLE      = 3'd0;
  localparam logic [2:0] ST_START     = 3'd1;
  localparam logic [2:0] ST_WAIT_BUSY = 3'd2;
  localparam logic [2:0] ST_WAIT_DONE = 3'd3;
  localparam logic [2:0] ST_RESP      = 3'd4;

  localparam logic RSP_ERR_TIMEOUT = 1'b1;

  function automatic int clog2_min1(input int n);
    int r;
    r = 0;
    while ((1 << r) < n) r++;
    return (r < 1) ? 1 : r;
  endfunction

endpackage

// File: rtl/rr_arbiter.sv
// Round-robin arbiter, purely combinational.
//   req     : request vector, bit i = requester i
//   ptr     : highest-priority index; scanning wraps from ptr upward
//   gnt_idx : index of the first set request at or after ptr (0 when none)
//   gnt_any : at least one request is set
module rr_arbiter
  import perm_sched_pkg::*;
#(
  parameter int NREQ = 4,
  parameter int IDW  = clog2_min1(NREQ)
) (
  input  logic [NREQ-1:0] req,
  input  logic [IDW-1:0]  ptr,
  output logic [IDW-1:0]  gnt_idx,
  output logic            gnt_any
);

  int unsigned idx;

  always_comb begin
    gnt_idx = '0;
    gnt_any = 1'b0;
    idx     = 0;
    for (int k = 0; k < NREQ; k++) begin
      idx = (int'(ptr) + k) % NREQ;
      if (!gnt_any && req[idx]) begin
        gnt_any = 1'b1;
        gnt_idx = IDW'(idx);
      end
    end
  end

endmodule

// File: rtl/perm_req_scheduler.sv
// Shares one permutation unit among NREQ requesters.
// Captures a granted request word, pulses start to the unit, waits for it to go
// busy and then done (or time out), and returns the result on one tagged
// response channel held until the consumer accepts it.
//   clk, rst          : clock, synchronous active-high reset
//   req_valid/req_data: per-requester request and word (requester i at [i*WIDTH +: WIDTH])
//   req_ack           : one-cycle capture pulse per requester
//   rsp_valid/ready   : response handshake; rsp_id, rsp_data, rsp_err payload
//   perm_start/perm_in: start pulse and operand to the unit
//   perm_ready/out    : unit idle/done flag and result
//   busy              : scheduler not idle
// All outputs are registered.
module perm_req_scheduler
  import perm_sched_pkg::*;
#(
  parameter int WIDTH   = 25,
  parameter int NREQ    = 4,
  parameter int IDW     = clog2_min1(NREQ),
  parameter int TIMEOUT = 64,
  parameter int TW      = clog2_min1(TIMEOUT + 1)
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic [NREQ-1:0]       req_valid,
  input  logic [NREQ*WIDTH-1:0] req_data,
  output logic [NREQ-1:0]       req_ack,
  output logic                  rsp_valid,
  input  logic                  rsp_ready,
  output logic [IDW-1:0]        rsp_id,
  output logic [WIDTH-1:0]      rsp_data,
  output logic                  rsp_err,
  output logic                  perm_start,
  output logic [WIDTH-1:0]      perm_in,
  input  logic                  perm_ready,
  input  logic [WIDTH-1:0]      perm_out,
  output logic                  busy
);

  logic [2:0]       state_q, state_nxt;
  logic [IDW-1:0]   ptr_q, ptr_d;
  logic [IDW-1:0]   id_q, id_d;
  logic [TW-1:0]    timer_q, timer_d;
  logic [NREQ-1:0]  ack_q, ack_d;
  logic             start_q, start_d;
  logic [WIDTH-1:0] word_q, word_d;
  logic             rsp_valid_q, rsp_valid_d;
  logic [WIDTH-1:0] rsp_data_q, rsp_data_d;
  logic             rsp_err_q, rsp_err_d;
  logic             busy_q, busy_d;

  logic [IDW-1:0]   gnt_idx;
  logic             gnt_any;
  logic             timeout_hit;

  // Requests are masked by perm_ready so nothing is granted while the unit is occupied.
  rr_arbiter #(
    .NREQ (NREQ),
    .IDW  (IDW)
  ) u_arb (
    .req     (req_valid & {NREQ{perm_ready}}),
    .ptr     (ptr_q),
    .gnt_idx (gnt_idx),
    .gnt_any (gnt_any)
  );

  assign timeout_hit = (timer_q == TW'(TIMEOUT - 1));

  // State register
  always_ff @(posedge clk) begin
    if (rst) state_q <= ST_IDLE;
    else     state_q <= state_nxt;
  end

  // Next-state logic; a timeout in WAIT_BUSY beats the move to WAIT_DONE,
  // while completion in WAIT_DONE beats a simultaneous timeout.
  always_comb begin
    state_nxt = state_q;
    case (state_q)
      ST_IDLE:      if (gnt_any) state_nxt = ST_START;
      ST_START:     state_nxt = ST_WAIT_BUSY;
      ST_WAIT_BUSY: begin
        if (timeout_hit)     state_nxt = ST_RESP;
        else if (!perm_ready) state_nxt = ST_WAIT_DONE;
      end
      ST_WAIT_DONE: if (perm_ready || timeout_hit) state_nxt = ST_RESP;
      ST_RESP:      if (rsp_ready) state_nxt = ST_IDLE;
      default:      state_nxt = ST_IDLE;
    endcase
  end

  // Next values of the registered outputs and datapath
  always_comb begin
    ptr_d       = ptr_q;
    id_d        = id_q;
    timer_d     = timer_q;
    ack_d       = '0;
    start_d     = 1'b0;
    word_d      = word_q;
    rsp_valid_d = rsp_valid_q;
    rsp_data_d  = rsp_data_q;
    rsp_err_d   = rsp_err_q;
    busy_d      = (state_nxt != ST_IDLE);
    case (state_q)
      ST_IDLE: begin
        if (gnt_any) begin
          ack_d   = NREQ'(1) << gnt_idx;
          start_d = 1'b1;
          word_d  = req_data[int'(gnt_idx)*WIDTH +: WIDTH];
          id_d    = gnt_idx;
          ptr_d   = (gnt_idx == IDW'(NREQ - 1)) ? '0 : gnt_idx + 1'b1;
        end
      end
      ST_START: timer_d = '0;
      ST_WAIT_BUSY: begin
        timer_d = timer_q + 1'b1;
        if (timeout_hit) begin
          rsp_valid_d = 1'b1;
          rsp_data_d  = '0;
          rsp_err_d   = RSP_ERR_TIMEOUT;
        end
      end
      ST_WAIT_DONE: begin
        timer_d = timer_q + 1'b1;
        if (perm_ready) begin
          rsp_valid_d = 1'b1;
          rsp_data_d  = perm_out;
          rsp_err_d   = 1'b0;
        end else if (timeout_hit) begin
          rsp_valid_d = 1'b1;
          rsp_data_d  = '0;
          rsp_err_d   = RSP_ERR_TIMEOUT;
        end
      end
      ST_RESP: if (rsp_ready) rsp_valid_d = 1'b0;
      default: ;
    endcase
  end

  // Output and datapath registers; reset clears every visible output.
  always_ff @(posedge clk) begin
    if (rst) begin
      ptr_q       <= '0;
      id_q        <= '0;
      timer_q     <= '0;
      ack_q       <= '0;
      start_q     <= 1'b0;
      word_q      <= '0;
      rsp_valid_q <= 1'b0;
      rsp_data_q  <= '0;
      rsp_err_q   <= 1'b0;
      busy_q      <= 1'b0;
    end else begin
      ptr_q       <= ptr_d;
      id_q        <= id_d;
      timer_q     <= timer_d;
      ack_q       <= ack_d;
      start_q     <= start_d;
      word_q      <= word_d;
      rsp_valid_q <= rsp_valid_d;
      rsp_data_q  <= rsp_data_d;
      rsp_err_q   <= rsp_err_d;
      busy_q      <= busy_d;
    end
  end

  assign req_ack    = ack_q;
  assign perm_start = start_q;
  assign perm_in    = word_q;
  assign rsp_valid  = rsp_valid_q;
  assign rsp_id     = id_q;
  assign rsp_data   = rsp_data_q;
  assign rsp_err    = rsp_err_q;
  assign busy       = busy_q;

endmodule

// File: tb/tb_perm_req_scheduler.sv
// Directed bench for perm_req_scheduler with a behavioural permutation unit
// (ready drops one cycle after start, result = input ^ 25'h0AAAAAA after 4
// busy cycles) and a queue of expected responses.
module tb_perm_req_scheduler;

  localparam int W    = 25;
  localparam int N    = 4;
  localparam int TO   = 8;
  localparam logic [W-1:0] KEY = 25'h0AAAAAA;

  logic           clk = 1'b0;
  logic           rst;
  logic [N-1:0]   req_valid;
  logic [N*W-1:0] req_data;
  logic [N-1:0]   req_ack;
  logic           rsp_valid;
  logic           rsp_ready;
  logic [1:0]     rsp_id;
  logic [W-1:0]   rsp_data;
  logic           rsp_err;
  logic           perm_start;
  logic [W-1:0]   perm_in;
  logic           perm_ready;
  logic [W-1:0]   perm_out;
  logic           busy;

  perm_req_scheduler #(.WIDTH(W), .NREQ(N), .TIMEOUT(TO)) dut (
    .clk        (clk),
    .rst        (rst),
    .req_valid  (req_valid),
    .req_data   (req_data),
    .req_ack    (req_ack),
    .rsp_valid  (rsp_valid),
    .rsp_ready  (rsp_ready),
    .rsp_id     (rsp_id),
    .rsp_data   (rsp_data),
    .rsp_err    (rsp_err),
    .perm_start (perm_start),
    .perm_in    (perm_in),
    .perm_ready (perm_ready),
    .perm_out   (perm_out),
    .busy       (busy)
  );

  always #5 clk = ~clk;

  // Behavioural unit
  logic       m_ready;
  logic [2:0] m_cnt;
  logic [W-1:0] m_out;
  logic       hang;
  logic       hold_low;

  always_ff @(posedge clk) begin
    if (rst) begin
      m_ready <= 1'b1;
      m_cnt   <= '0;
      m_out   <= '0;
    end else if (perm_start) begin
      m_ready <= 1'b0;
      m_cnt   <= 3'd3;
      m_out   <= perm_in ^ KEY;
    end else if (!m_ready) begin
      if (m_cnt != 0) m_cnt   <= m_cnt - 1'b1;
      else if (!hang) m_ready <= 1'b1;
    end
  end

  assign perm_ready = m_ready & ~hold_low;
  assign perm_out   = m_out;

  typedef struct packed {
    logic [1:0]   id;
    logic [W-1:0] data;
    logic         err;
  } rsp_t;

  rsp_t exp_q[$];

  int checks   = 0;
  int failures = 0;
  int n_start  = 0;
  int n_ack    = 0;
  int n_rspv   = 0;
  int word_k[N];
  bit rearm    = 0;

  function automatic logic [W-1:0] word(input int i, input int k);
    return W'(32'h00A5_0000 * (i + 1) + 32'h0001_1111 * (k + 1));
  endfunction

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  // One clock; outputs are sampled 1 time unit after the edge. Acked requesters
  // either drop req_valid or present their next word.
  task automatic tick();
    @(posedge clk);
    #1;
    if (perm_start) n_start++;
    if (rsp_valid)  n_rspv++;
    for (int i = 0; i < N; i++) begin
      if (req_ack[i]) begin
        n_ack++;
        if (rearm) begin
          word_k[i]++;
          req_data[i*W +: W] = word(i, word_k[i]);
        end else begin
          req_valid[i] = 1'b0;
        end
      end
    end
  endtask

  task automatic push(input int id, input logic [W-1:0] data, input logic err);
    rsp_t e;
    e.id = 2'(id); e.data = data; e.err = err;
    exp_q.push_back(e);
  endtask

  task automatic wait_rsp(input string tag, output int lat);
    rsp_t e;
    lat = 0;
    while (!rsp_valid && lat < 200) begin
      tick();
      lat++;
    end
    if (!rsp_valid) begin
      chk({tag, "_rsp_wait"}, 32'(rsp_valid), 32'd1);
    end else if (exp_q.size() == 0) begin
      chk({tag, "_unexpected_rsp"}, 32'(rsp_valid), 32'd0);
    end else begin
      e = exp_q.pop_front();
      chk({tag, "_id"},   32'(rsp_id),   32'(e.id));
      chk({tag, "_data"}, 32'(rsp_data), 32'(e.data));
      chk({tag, "_err"},  32'(rsp_err),  32'(e.err));
    end
  endtask

  task automatic accept(input string tag);
    tick();
    chk({tag, "_valid_drop"}, 32'(rsp_valid), 32'd0);
  endtask

  initial begin
    #200000;
    $display("FAIL global_timeout: got running expected finished");
    $fatal(1, "simulation time limit");
  end

  initial begin
    int lat;
    int ack0, start0;
    logic [W-1:0] d;

    rst = 1'b1; req_valid = '0; req_data = '0; rsp_ready = 1'b1;
    hang = 1'b0; hold_low = 1'b0;
    for (int i = 0; i < N; i++) word_k[i] = 0;
    repeat (3) tick();
    chk("rst_ack",   32'(req_ack),   32'd0);
    chk("rst_start", 32'(perm_start), 32'd0);
    chk("rst_valid", 32'(rsp_valid), 32'd0);
    chk("rst_busy",  32'(busy),      32'd0);
    chk("rst_data",  32'(rsp_data),  32'd0);
    chk("rst_pin",   32'(perm_in),   32'd0);
    rst = 1'b0;
    tick();

    // Round robin from pointer 0 with all requesters asserting
    rearm = 1;
    for (int i = 0; i < N; i++) req_data[i*W +: W] = word(i, 0);
    req_valid = 4'b1111;
    push(0, word(0, 0) ^ KEY, 1'b0);
    push(1, word(1, 0) ^ KEY, 1'b0);
    push(2, word(2, 0) ^ KEY, 1'b0);
    push(3, word(3, 0) ^ KEY, 1'b0);
    push(0, word(0, 1) ^ KEY, 1'b0);
    for (int j = 0; j < 5; j++) begin
      wait_rsp("rr", lat);
      if (j == 4) req_valid = '0;
      accept("rr");
    end
    rearm = 0;
    tick();

    // Single request with latency check
    n_start = 0;
    req_data[2*W +: W] = 25'h1234567;
    req_valid = 4'b0100;
    push(2, 25'h1234567 ^ KEY, 1'b0);
    tick();
    chk("single_ack",   32'(req_ack),    32'b0100);
    chk("single_start", 32'(perm_start), 32'd1);
    chk("single_pin",   32'(perm_in),    32'h1234567);
    chk("single_busy",  32'(busy),       32'd1);
    wait_rsp("single", lat);
    chk("single_latency", 32'(lat + 1), 32'd7);
    chk("single_nstart",  32'(n_start), 32'd1);
    accept("single");
    chk("single_idle", 32'(busy), 32'd0);
    tick();

    // Backpressure: response held 10 cycles while another request waits
    rsp_ready = 1'b0;
    d = 25'h0777123;
    req_data[0 +: W] = d;
    req_valid = 4'b0001;
    push(0, d ^ KEY, 1'b0);
    wait_rsp("bp", lat);
    req_data[1*W +: W] = 25'h1ABCDEF;
    req_valid[1] = 1'b1;
    ack0 = n_ack; start0 = n_start;
    for (int c = 0; c < 10; c++) begin
      tick();
      chk("bp_hold_valid", 32'(rsp_valid), 32'd1);
      chk("bp_hold_data",  32'(rsp_data),  32'(d ^ KEY));
      chk("bp_hold_id",    32'(rsp_id),    32'd0);
    end
    chk("bp_no_ack",   32'(n_ack),   32'(ack0));
    chk("bp_no_start", 32'(n_start), 32'(start0));
    rsp_ready = 1'b1;
    push(1, 25'h1ABCDEF ^ KEY, 1'b0);
    tick();
    chk("bp_release_valid", 32'(rsp_valid), 32'd0);
    chk("bp_release_idle",  32'(busy),      32'd0);
    wait_rsp("bp_next", lat);
    accept("bp_next");

    // Timeout: unit never finishes
    hang = 1'b1;
    req_data[3*W +: W] = 25'h0123456;
    req_valid = 4'b1000;
    push(3, '0, 1'b1);
    wait_rsp("to", lat);
    chk("to_latency", 32'(lat), 32'd10);
    hang = 1'b0;
    accept("to");
    req_data[2*W +: W] = 25'h1555000;
    req_valid = 4'b0100;
    push(2, 25'h1555000 ^ KEY, 1'b0);
    wait_rsp("to_after", lat);
    accept("to_after");

    // Unit not ready in IDLE
    hold_low = 1'b1;
    req_data[0 +: W] = 25'h0F0F0F0;
    req_valid = 4'b0001;
    ack0 = n_ack; start0 = n_start;
    repeat (6) tick();
    chk("nr_no_ack",   32'(n_ack),   32'(ack0));
    chk("nr_no_start", 32'(n_start), 32'(start0));
    chk("nr_idle",     32'(busy),    32'd0);
    hold_low = 1'b0;
    push(0, 25'h0F0F0F0 ^ KEY, 1'b0);
    wait_rsp("nr", lat);
    accept("nr");

    // Reset during WAIT_DONE
    req_data[1*W +: W] = 25'h0333333;
    req_valid = 4'b0010;
    repeat (3) tick();
    rst = 1'b1;
    tick();
    rst = 1'b0;
    chk("mr_ack",   32'(req_ack),    32'd0);
    chk("mr_start", 32'(perm_start), 32'd0);
    chk("mr_valid", 32'(rsp_valid),  32'd0);
    chk("mr_id",    32'(rsp_id),     32'd0);
    chk("mr_data",  32'(rsp_data),   32'd0);
    chk("mr_err",   32'(rsp_err),    32'd0);
    chk("mr_pin",   32'(perm_in),    32'd0);
    chk("mr_busy",  32'(busy),       32'd0);
    n_rspv = 0;
    repeat (15) tick();
    chk("mr_no_rsp", 32'(n_rspv), 32'd0);
    // Pointer back at 0: requester 0 wins over requester 3
    req_data[0 +: W]   = 25'h0000ABC;
    req_data[3*W +: W] = 25'h1FFF000;
    req_valid = 4'b1001;
    push(0, 25'h0000ABC ^ KEY, 1'b0);
    wait_rsp("mr_fresh", lat);
    req_valid = '0;
    accept("mr_fresh");
    repeat (3) tick();
    chk("queue_empty", 32'(exp_q.size()), 32'd0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/perm_req_scheduler.md
Name: perm_req_scheduler

Overview:
- Shares one permutation unit among NREQ requesters.
- Captures each request word, starts the unit, and waits for completion.
- Returns the result on a single tagged response channel.
- Sits between requester clients and the permutation top; it is the unit's only driver of start and input.

Parameters:
- WIDTH, 25: permutation word width in bits.
- NREQ, 4: number of requesters; must be 2 or more.
- IDW, $clog2(NREQ): requester-id width.
- TIMEOUT, 64: maximum cycles from start to completion before an error is returned.
- TW, $clog2(TIMEOUT+1): timeout-counter width.

Ports:
- clk  in  1  system clock, rising edge
- rst  in  1  reset; fixed as synchronous, active-high
- req_valid  in  NREQ  request pending; bit i belongs to requester i
- req_data  in  NREQ*WIDTH  requester i's word at bits [i*WIDTH +: WIDTH]
- req_ack  out  NREQ  one-cycle pulse: requester i's word was captured
- rsp_valid  out  1  response available
- rsp_ready  in  1  consumer accepts the response
- rsp_id  out  IDW  index of the served requester
- rsp_data  out  WIDTH  permutation result; 0 on error
- rsp_err  out  1  timeout occurred
- perm_start  out  1  one-cycle start pulse to the unit
- perm_in  out  WIDTH  word presented to the unit
- perm_ready  in  1  unit idle/done; low while computing
- perm_out  in  WIDTH  unit result
- busy  out  1  scheduler is not in IDLE

Behaviour:
- All outputs are registered.
- Reset:
  - All outputs are 0, state is IDLE, round-robin pointer is 0, timer is 0.
  - rst mid-operation abandons the transaction with no response and no ack.
  - The unit shares rst.
- States: IDLE, START, WAIT_BUSY, WAIT_DONE, RESP.
- IDLE:
  - Grants only when |req_valid and perm_ready==1.
  - Grant goes to the first set bit scanning circularly from the pointer.
  - Next edge: capture req_data[g] into the input register, set id to g, set pointer to (g+1) mod NREQ, go to START.
- START (1 cycle):
  - req_ack[g]=1 and perm_start=1.
  - perm_in holds the captured word from START until RESP exits.
  - Clear the timer, go to WAIT_BUSY.
- WAIT_BUSY: perm_ready==0 goes to WAIT_DONE. The timer increments every cycle in WAIT_BUSY and WAIT_DONE.
- WAIT_DONE: perm_ready==1 latches rsp_data=perm_out, rsp_err=0, rsp_valid=1, and goes to RESP.
- Timeout:
  - Triggers when the timer reaches TIMEOUT-1 in WAIT_BUSY or WAIT_DONE without completion.
  - Response is rsp_err=1, rsp_data=0, rsp_valid=1, then RESP.
  - Completion and timeout in the same cycle: completion wins.
- RESP:
  - rsp_valid, rsp_id, rsp_data and rsp_err hold stable until rsp_ready==1.
  - On that edge rsp_valid drops and state goes to IDLE.
  - No arbitration happens in the RESP cycle, so there is at least one IDLE cycle between transactions.
- Requester rule:
  - Deassert req_valid in the cycle after seeing req_ack, or change req_data before the next IDLE.
  - A req_valid still high in the next IDLE is a new request.
  - req_valid may fall before it is acked; nothing is captured in that case.
- Nominal latency with a unit that drops ready 1 cycle after start and computes for K cycles:
  - request visible in IDLE at cycle t
  - ack and start at t+1
  - rsp_valid at t+K+3 (exact offset verified against the unit model)
- Fairness: a continuously asserting requester waits at most NREQ-1 other transactions.

Decomposition:
- Package perm_sched_pkg holds:
  - state encoding localparams
  - clog2-with-minimum-1 helper for IDW and TW
  - response-error code constant
- Sub-module rr_arbiter #(NREQ) contains:
  - inputs: req vector, pointer
  - outputs: grant index and any-grant flag (combinational)
- The FSM, timer, capture registers and pointer update stay in perm_req_scheduler.

Test Plan (behavioural unit model: ready drops 1 cycle after start, result = input XOR 25'h0AAAAAA after 4 busy cycles):
- Single request: req_valid=4'b0100, req_data[2]=25'h1234567. Expect a req_ack[2] pulse, one perm_start, rsp_id=2, rsp_data=25'h1234567^25'h0AAAAAA, rsp_err=0.
- Round robin: all four req_valid held high with acks honoured. Expect service order 0,1,2,3,0 and no requester served twice before the others.
- Backpressure: rsp_ready=0 for 10 cycles after rsp_valid. Expect outputs stable, no new ack or start, then IDLE one cycle after rsp_ready=1.
- Timeout: model never raises ready, TIMEOUT=8. Expect rsp_err=1, rsp_data=0, rsp_id correct, and the next request served normally afterwards.
- Unit not ready: perm_ready held 0 in IDLE with req_valid=4'b0001. Expect no ack or start until perm_ready=1.
- Reset mid-operation: rst=1 for 1 cycle during WAIT_DONE. Expect all outputs 0 next cycle, no response issued, pointer 0, and a fresh request served afterwards.
